// File: rtl/dpram_fifo_ctrl.sv
// Valid/ready FIFO controller for a synchronous dual-port RAM with a registered read.
// Port A writes only, port B reads only; the controller keeps pointers, occupancy and flags.
module dpram_fifo_ctrl #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             ram_we_a,
  output logic [AW-1:0]    ram_addr_a,
  output logic [WIDTH-1:0] ram_din_a,
  output logic             ram_we_b,
  output logic [AW-1:0]    ram_addr_b,
  output logic [WIDTH-1:0] ram_din_b,
  input  logic [WIDTH-1:0] ram_dout_b,
  output logic [AW:0]      level,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   wr_cnt_q, wr_cnt_d;
  logic [AW:0]   rd_cnt_q, rd_cnt_d;
  logic          push_d_q, push_d_d;
  logic          push;
  logic          pop;

  assign full    = (wr_cnt_q == FULL_CNT);
  assign empty   = (wr_cnt_q == '0);
  assign level   = wr_cnt_q;
  assign s_ready = !full;
  assign m_valid = (rd_cnt_q != '0);
  assign push    = s_valid & s_ready;
  assign pop     = m_valid & m_ready;

  assign rd_ptr_inc = rd_ptr_q + AW'(1);

  assign ram_we_a   = push;
  assign ram_addr_a = wr_ptr_q;
  assign ram_din_a  = s_data;
  assign ram_we_b   = 1'b0;
  assign ram_din_b  = '0;
  // Look ahead on pop so the registered read always presents the next head entry.
  assign ram_addr_b = pop ? rd_ptr_inc : rd_ptr_q;
  assign m_data     = ram_dout_b;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_inc;
    wr_cnt_d = wr_cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // Reader count trails by one cycle so an entry is visible only after its RAM write lands.
    rd_cnt_d = rd_cnt_q + (AW+1)'(push_d_q) - (AW+1)'(pop);
    push_d_d = push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      push_d_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
      push_d_q <= push_d_d;
    end
  end

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Bench for dpram_fifo_ctrl with a behavioural registered-read dual-port RAM attached.
module tb_dpram_fifo_ctrl;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid, s_ready, m_valid, m_ready;
  logic [WIDTH-1:0] s_data, m_data;
  logic             ram_we_a, ram_we_b;
  logic [AW-1:0]    ram_addr_a, ram_addr_b;
  logic [WIDTH-1:0] ram_din_a, ram_din_b, ram_dout_b;
  logic [AW:0]      level;
  logic             full, empty;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] sbq[$];

  always #5 clk = ~clk;

  dpram_fifo_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .ram_we_a(ram_we_a), .ram_addr_a(ram_addr_a), .ram_din_a(ram_din_a),
    .ram_we_b(ram_we_b), .ram_addr_b(ram_addr_b), .ram_din_b(ram_din_b),
    .ram_dout_b(ram_dout_b),
    .level(level), .full(full), .empty(empty)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (ram_we_a) mem[ram_addr_a] <= ram_din_a;
    if (ram_we_b) mem[ram_addr_b] <= ram_din_b;
    ram_dout_b <= mem[ram_addr_b];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      settle();
      checks++;
      if ({s_ready, m_valid, empty, full, level, ram_we_a, ram_we_b} !== {1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d: got s_ready=%b m_valid=%b empty=%b full=%b level=%0d we_a=%b we_b=%b, want 1 0 1 0 0 0 0",
                 i, s_ready, m_valid, empty, full, level, ram_we_a, ram_we_b);
      end
      step();
    end
    settle();
    checks++;
    if (ram_din_b !== 8'h00) begin
      errors++;
      $display("FAIL reset_din_b: got %h want 00", ram_din_b);
    end
    step();
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] exp;
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b0;
    settle();
    checks++;
    if (ram_we_a !== 1'b1 || ram_addr_a !== 3'd0 || ram_din_a !== 8'hA5) begin
      errors++;
      $display("FAIL single_write: got we=%b addr=%0d din=%h want 1 0 a5", ram_we_a, ram_addr_a, ram_din_a);
    end
    sbq.push_back(8'hA5);
    step();
    s_valid = 1'b0;
    settle();
    checks++;
    if (level !== 4'd1 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_cyc1: got level=%0d m_valid=%b want 1 0", level, m_valid);
    end
    step();
    for (int c = 2; c < 7; c++) begin
      settle();
      checks++;
      if (m_valid !== 1'b1 || m_data !== sbq[0]) begin
        errors++;
        $display("FAIL single_stall cyc=%0d: got m_valid=%b m_data=%h want 1 %h", c, m_valid, m_data, sbq[0]);
      end
      step();
    end
    m_ready = 1'b1;
    settle();
    exp = sbq.pop_front();
    checks++;
    if (m_valid !== 1'b1 || m_data !== exp) begin
      errors++;
      $display("FAIL single_pop: got m_valid=%b m_data=%h want 1 %h", m_valid, m_data, exp);
    end
    step();
    m_ready = 1'b0;
    settle();
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL single_after: got m_valid=%b empty=%b want 0 1", m_valid, empty);
    end
    step();
  endtask

  task automatic test_fill();
    int n;
    m_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1; s_data = 8'(i + 1);
      settle();
      checks++;
      if (s_ready !== 1'b1) begin
        errors++;
        $display("FAIL fill_ready push=%0d: got s_ready=%b want 1", i, s_ready);
      end
      sbq.push_back(8'(i + 1));
      step();
    end
    s_valid = 1'b1; s_data = 8'h09;
    settle();
    checks++;
    if (full !== 1'b1 || s_ready !== 1'b0 || level !== 4'd8 || ram_we_a !== 1'b0) begin
      errors++;
      $display("FAIL fill_full: got full=%b s_ready=%b level=%0d we_a=%b want 1 0 8 0", full, s_ready, level, ram_we_a);
    end
    step();
    s_valid = 1'b0; m_ready = 1'b1;
    settle();
    checks++;
    if (full !== 1'b1 || s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== sbq[0]) begin
      errors++;
      $display("FAIL fill_pop_full: got full=%b s_ready=%b m_valid=%b m_data=%h want 1 0 1 %h",
               full, s_ready, m_valid, m_data, sbq[0]);
    end
    if (m_valid === 1'b1) void'(sbq.pop_front());
    step();
    n = 0;
    while (sbq.size() > 0 && n < 20) begin
      settle();
      checks++;
      if (m_valid !== 1'b1 || m_data !== sbq[0] || (n == 0 && s_ready !== 1'b1)) begin
        errors++;
        $display("FAIL fill_drain n=%0d: got m_valid=%b m_data=%h s_ready=%b want 1 %h 1", n, m_valid, m_data, s_ready, sbq[0]);
      end
      if (m_valid === 1'b1) void'(sbq.pop_front());
      step();
      n++;
    end
    settle();
    checks++;
    if (sbq.size() != 0 || m_valid !== 1'b0) begin
      errors++;
      $display("FAIL fill_end: got left=%0d m_valid=%b want 0 0", sbq.size(), m_valid);
    end
    sbq.delete();
    m_ready = 1'b0;
    step();
  endtask

  task automatic test_stream();
    bit prev_push = 1'b0;
    bit exp_mv;
    int vis;
    int n;
    s_valid = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_data = 8'(i);
      settle();
      vis = sbq.size() - int'(prev_push);
      exp_mv = (vis > 0);
      checks++;
      if (m_valid !== exp_mv || level !== 4'(sbq.size()) || (i >= 2 && m_valid !== 1'b1)) begin
        errors++;
        $display("FAIL stream_flags i=%0d: got m_valid=%b level=%0d want %b %0d", i, m_valid, level, exp_mv, sbq.size());
      end
      if (exp_mv) begin
        checks++;
        if (m_data !== sbq[0]) begin
          errors++;
          $display("FAIL stream_data i=%0d: got %h want %h", i, m_data, sbq[0]);
        end
        void'(sbq.pop_front());
      end
      sbq.push_back(s_data);
      prev_push = 1'b1;
      step();
    end
    s_valid = 1'b0;
    n = 0;
    while (sbq.size() > 0 && n < 10) begin
      settle();
      vis = sbq.size() - int'(prev_push);
      prev_push = 1'b0;
      if (vis > 0) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== sbq[0]) begin
          errors++;
          $display("FAIL stream_drain n=%0d: got m_valid=%b m_data=%h want 1 %h", n, m_valid, m_data, sbq[0]);
        end
        void'(sbq.pop_front());
      end
      step();
      n++;
    end
    settle();
    checks++;
    if (sbq.size() != 0 || m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL stream_end: got left=%0d m_valid=%b empty=%b want 0 0 1", sbq.size(), m_valid, empty);
    end
    m_ready = 1'b0;
    step();
  endtask

  task automatic test_random();
    bit prev_push = 1'b0;
    bit stall_prev = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    bit exp_ready, exp_mv;
    int vis;
    void'($urandom(32'd1234));
    for (int i = 0; i < 2000 + 12; i++) begin
      if (i < 2000) begin
        s_valid = ($urandom_range(0, 99) < 60);
        m_ready = ($urandom_range(0, 99) < 55);
      end else begin
        s_valid = 1'b0;
        m_ready = 1'b1;
      end
      s_data = 8'($urandom_range(0, 255));
      settle();
      vis = sbq.size() - int'(prev_push);
      exp_ready = (sbq.size() < DEPTH);
      exp_mv = (vis > 0);
      checks++;
      if (s_ready !== exp_ready || m_valid !== exp_mv || level !== 4'(sbq.size()) ||
          full !== (sbq.size() == DEPTH) || empty !== (sbq.size() == 0)) begin
        errors++;
        $display("FAIL rand_flags i=%0d: got s_ready=%b m_valid=%b level=%0d full=%b empty=%b want %b %b %0d",
                 i, s_ready, m_valid, level, full, empty, exp_ready, exp_mv, sbq.size());
      end
      if (exp_mv) begin
        checks++;
        if (m_data !== sbq[0] || (stall_prev && m_data !== prev_data)) begin
          errors++;
          $display("FAIL rand_data i=%0d: got %h want %h", i, m_data, sbq[0]);
        end
      end
      stall_prev = exp_mv && !m_ready;
      prev_data = m_data;
      if (exp_mv && m_ready) void'(sbq.pop_front());
      prev_push = s_valid && exp_ready;
      if (prev_push) sbq.push_back(s_data);
      step();
    end
    settle();
    checks++;
    if (sbq.size() != 0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rand_end: got left=%0d empty=%b want 0 1", sbq.size(), empty);
    end
    sbq.delete();
    s_valid = 1'b0; m_ready = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h50 + i);
      step();
    end
    s_valid = 1'b0;
    step(); step();
    settle();
    checks++;
    if (level !== 4'd5 || m_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: got level=%0d m_valid=%b want 5 1", level, m_valid);
    end
    step();
    rst = 1'b1; s_valid = 1'b1; s_data = 8'hFF; m_ready = 1'b1;
    step();
    rst = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    settle();
    checks++;
    if (level !== 4'd0 || m_valid !== 1'b0 || s_ready !== 1'b1 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_after: got level=%0d m_valid=%b s_ready=%b empty=%b want 0 0 1 1", level, m_valid, s_ready, empty);
    end
    step();
    s_valid = 1'b1; s_data = 8'h3C;
    settle();
    checks++;
    if (ram_we_a !== 1'b1 || ram_addr_a !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_push: got we=%b addr=%0d want 1 0", ram_we_a, ram_addr_a);
    end
    sbq.push_back(8'h3C);
    step();
    s_valid = 1'b0;
    settle();
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_lat1: got m_valid=%b want 0", m_valid);
    end
    step();
    m_ready = 1'b1;
    settle();
    checks++;
    if (m_valid !== 1'b1 || m_data !== sbq[0]) begin
      errors++;
      $display("FAIL rstmid_data: got m_valid=%b m_data=%h want 1 %h", m_valid, m_data, sbq[0]);
    end
    void'(sbq.pop_front());
    step();
    settle();
    checks++;
    if (m_valid !== 1'b0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_alone: got m_valid=%b empty=%b want 0 1", m_valid, empty);
    end
    m_ready = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_stream();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
Name: dpram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly in front of the team's synchronous dual-port RAM (registered read, 1-cycle read latency) and turns it into a valid/ready stream buffer.
- RAM port A is used write-only and RAM port B read-only.
- The controller owns the pointers, occupancy and flags, and handles the RAM's read latency so the downstream side sees zero-bubble streaming.

Parameters:
- DEPTH, 8, number of RAM entries; must be a power of 2 and at least 2; must match the attached RAM.
- WIDTH, 8, data width; must match the attached RAM.
- AW, $clog2(DEPTH), address width (localparam).

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- s_valid  input  1  upstream data valid.
- s_ready  output  1  upstream may push.
- s_data  input  WIDTH  upstream data.
- m_valid  output  1  downstream head entry valid.
- m_ready  input  1  downstream accepts the head entry.
- m_data  output  WIDTH  head entry; driven directly from ram_dout_b.
- ram_we_a  output  1  RAM port A write enable.
- ram_addr_a  output  AW  RAM port A address.
- ram_din_a  output  WIDTH  RAM port A write data.
- ram_we_b  output  1  RAM port B write enable; constant 0.
- ram_addr_b  output  AW  RAM port B read address.
- ram_din_b  output  WIDTH  constant 0.
- ram_dout_b  input  WIDTH  RAM port B registered read data.
- level  output  AW+1  writer-side occupancy, 0..DEPTH.
- full  output  1  level == DEPTH.
- empty  output  1  level == 0.

Behaviour:
- State: wr_ptr, rd_ptr (AW bits, wrap modulo DEPTH), wr_cnt (level), rd_cnt (reader-visible count, AW+1 bits), push_d (1-bit delayed push).
- Reset (rst=1 at an edge): wr_ptr=0, rd_ptr=0, wr_cnt=0, rd_cnt=0, push_d=0. Consequences:
  - s_ready=1, m_valid=0, full=0, empty=1, level=0.
  - Reset mid-operation discards all contents; RAM contents are not cleared.
- push = s_valid & s_ready.
- s_ready = !full. This is combinational from registered state only; there is no combinational path from m_ready.
- When push=1: ram_we_a=1, ram_addr_a=wr_ptr, ram_din_a=s_data; wr_ptr increments at the edge. When push=0: ram_we_a=0.
  - ram_addr_a and ram_din_a may be any value when ram_we_a=0; the implementation drives wr_ptr and s_data.
- pop = m_valid & m_ready.
- m_valid = (rd_cnt != 0). rd_ptr increments on pop.
- ram_addr_b = pop ? rd_ptr+1 : rd_ptr (combinational, wrapping). This keeps ram_dout_b equal to mem[head] every cycle, so m_data is stable while m_valid & !m_ready.
- Visibility latency:
  - A push at cycle t writes the RAM at the end of t.
  - push_d=1 in t+1, so rd_cnt increments at the end of t+1.
  - m_valid and correct m_data appear in cycle t+2.
  - Minimum push-to-m_valid latency is 2 cycles.
  - Sustained throughput is 1 entry/cycle once primed.
- Counter updates per edge:
  - wr_cnt += push - pop.
  - rd_cnt += push_d - pop.
  - Simultaneous push and pop leave wr_cnt unchanged.
- Invariants:
  - rd_cnt <= wr_cnt <= DEPTH.
  - wr_cnt - rd_cnt is 0 or 1.
- Full: s_ready=0 and s_valid is ignored. A pop in the same cycle does not make s_ready=1 that cycle; s_ready rises on the next cycle.
- Empty: m_valid=0 and m_ready is ignored. There is no underflow and pointers do not move.
- A write and a read of the same RAM address in the same cycle cannot corrupt output. The visibility rule guarantees the read port never presents an entry before it is committed.
- Pointer wrap: DEPTH-1 -> 0, with no extra state. full and empty are derived from wr_cnt, not pointer comparison.
- No internal data storage; m_data has no extra register stage.

Test Plan:
- Reset then idle (DEPTH=8, WIDTH=8) -> s_ready=1, m_valid=0, empty=1, level=0, ram_we_a=0, ram_we_b=0 for 10 cycles.
- Push 0xA5 at cycle 0 with m_ready=0 -> level=1 at cycle 1; m_valid=1 with m_data=0xA5 from cycle 2; m_data held stable for 5 stalled cycles; m_ready=1 at cycle 7 -> m_valid=0, empty=1 at cycle 8.
- Push 0x01..0x08 back-to-back with m_ready=0 -> full=1, s_ready=0, level=8 after the 8th push; a 9th push of 0x09 is ignored. Then hold m_ready=1 -> m_data sequence 0x01..0x08 on consecutive cycles, then m_valid=0.
- Continuous streaming with s_valid=1 and m_ready=1 for 40 cycles, data = incrementing counter -> output matches in order with no gaps after the initial 2-cycle latency; level stays at 1 or 2; pointers wrap 5 times.
- Random s_valid/m_ready (seeded, 2000 cycles) checked against a scoreboard queue -> no loss, duplication or reorder; invariants hold every cycle; m_data stable whenever m_valid & !m_ready.
- Fill to 5 entries, assert rst for 1 cycle during a simultaneous push and pop -> next cycle level=0, m_valid=0, s_ready=1. A subsequent push of 0x3C appears alone on m_data 2 cycles later.
